// File: rtl/bubble_pkg.sv
// Shared types and constants for the screen-object movers: item FSM encoding,
// fixed-point layout of vertical positions and default playfield geometry.
package bubble_pkg;

    typedef enum logic [1:0] {
        ITEM_IDLE    = 2'd0,
        ITEM_FALLING = 2'd1,
        ITEM_LANDED  = 2'd2,
        ITEM_BLINK   = 2'd3
    } item_state_t;

    localparam int COORD_W      = 11;
    localparam int FRAC_BITS    = 4;
    localparam int SCREEN_W_DEF = 640;
    localparam int FLOOR_Y_DEF  = 440;

    // Keeps a requested left edge from pushing the object past the right border.
    function automatic logic [COORD_W-1:0] clamp_left_x(
        input logic [COORD_W-1:0] x,
        input logic [COORD_W-1:0] max_x
    );
        return (x > max_x) ? max_x : x;
    endfunction

endpackage

// File: rtl/rect_offset_calc.sv
// Registered pixel-to-object stage: item-local offsets plus the inside qualifier,
// one cycle after the scan position is sampled.
module rect_offset_calc
    import bubble_pkg::*;
#(
    parameter int OBJ_W = 25,
    parameter int OBJ_H = 25
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic [COORD_W-1:0] pixel_x_i,
    input  logic [COORD_W-1:0] pixel_y_i,
    input  logic [COORD_W-1:0] top_left_x_i,
    input  logic [COORD_W-1:0] top_left_y_i,
    input  logic               enable_i,
    output logic [COORD_W-1:0] offset_x_o,
    output logic [COORD_W-1:0] offset_y_o,
    output logic               inside_o
);

    logic [COORD_W-1:0] dx_s;
    logic [COORD_W-1:0] dy_s;
    logic               inside_s;
    logic [COORD_W-1:0] offset_x_q;
    logic [COORD_W-1:0] offset_y_q;
    logic               inside_q;

    // Wrapped differences: pixels left of / above the box become large and fail the bound.
    always_comb begin
        dx_s     = pixel_x_i - top_left_x_i;
        dy_s     = pixel_y_i - top_left_y_i;
        inside_s = enable_i && (dx_s < COORD_W'(OBJ_W)) && (dy_s < COORD_W'(OBJ_H));
    end

    // Offsets are zeroed outside the box so the ROM index never leaves range.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            offset_x_q <= '0;
            offset_y_q <= '0;
            inside_q   <= 1'b0;
        end else begin
            offset_x_q <= inside_s ? dx_s : '0;
            offset_y_q <= inside_s ? dy_s : '0;
            inside_q   <= inside_s;
        end
    end

    assign offset_x_o = offset_x_q;
    assign offset_y_o = offset_y_q;
    assign inside_o   = inside_q;

endmodule

// File: rtl/bonus_item_mover.sv
// Super-rope bonus pickup: falls under gravity, rests on the floor, blinks, expires;
// collection ends it early. Feeds the 25x25 bitmap ROM stage.
module bonus_item_mover
    import bubble_pkg::*;
#(
    parameter int OBJ_W         = 25,
    parameter int OBJ_H         = 25,
    parameter int SCREEN_W      = SCREEN_W_DEF,
    parameter int FLOOR_Y       = FLOOR_Y_DEF,
    parameter int GRAVITY       = 2,
    parameter int MAX_SPEED     = 64,
    parameter int LINGER_FRAMES = 300,
    parameter int BLINK_FRAMES  = 120,
    parameter int BLINK_PERIOD  = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               startOfFrame,
    input  logic [COORD_W-1:0] pixelX,
    input  logic [COORD_W-1:0] pixelY,
    input  logic               spawn,
    input  logic [COORD_W-1:0] spawnX,
    input  logic               collected,
    output logic [COORD_W-1:0] offsetX,
    output logic [COORD_W-1:0] offsetY,
    output logic               InsideRectangle,
    output logic               active,
    output logic               pickup
);

    localparam int POS_W   = COORD_W + FRAC_BITS;
    localparam int SPEED_W = 7 + FRAC_BITS;
    localparam int CNT_W   = $clog2((LINGER_FRAMES > BLINK_FRAMES) ? LINGER_FRAMES : BLINK_FRAMES);
    localparam int PH_W    = $clog2(BLINK_PERIOD) + 1;
    localparam logic [POS_W-1:0] FLOOR_POS = POS_W'((FLOOR_Y - OBJ_H) << FRAC_BITS);

    item_state_t        state_q,     state_d;
    logic [COORD_W-1:0] tlx_q,       tlx_d;
    logic [POS_W-1:0]   pos_y_q,     pos_y_d;
    logic [SPEED_W-1:0] speed_q,     speed_d;
    logic [CNT_W-1:0]   frame_cnt_q, frame_cnt_d;
    logic [PH_W-1:0]    phase_cnt_q, phase_cnt_d;
    logic               visible_q,   visible_d;
    logic               pickup_q,    pickup_d;

    logic [SPEED_W-1:0] speed_sum_s;
    logic [SPEED_W-1:0] speed_new_s;
    logic [POS_W-1:0]   pos_new_s;
    logic               hits_floor_s;
    logic               is_active_s;

    // Gravity integrator candidate for the next frame, plus floor contact test.
    always_comb begin
        speed_sum_s  = speed_q + SPEED_W'(GRAVITY);
        speed_new_s  = (speed_sum_s > SPEED_W'(MAX_SPEED)) ? SPEED_W'(MAX_SPEED) : speed_sum_s;
        pos_new_s    = pos_y_q + POS_W'(speed_new_s);
        hits_floor_s = ({1'b0, pos_new_s[POS_W-1:FRAC_BITS]} + (COORD_W+1)'(OBJ_H))
                       >= (COORD_W+1)'(FLOOR_Y);
        is_active_s  = (state_q != ITEM_IDLE);
    end

    // Lifetime FSM; collection outranks the frame update, which outranks spawn.
    always_comb begin
        state_d     = state_q;
        tlx_d       = tlx_q;
        pos_y_d     = pos_y_q;
        speed_d     = speed_q;
        frame_cnt_d = frame_cnt_q;
        phase_cnt_d = phase_cnt_q;
        visible_d   = visible_q;
        pickup_d    = 1'b0;
        if (collected && is_active_s) begin
            state_d     = ITEM_IDLE;
            pickup_d    = 1'b1;
            speed_d     = '0;
            frame_cnt_d = '0;
            phase_cnt_d = '0;
            visible_d   = 1'b1;
        end else if (startOfFrame && is_active_s) begin
            case (state_q)
                ITEM_FALLING: begin
                    if (hits_floor_s) begin
                        state_d     = ITEM_LANDED;
                        pos_y_d     = FLOOR_POS;
                        speed_d     = '0;
                        frame_cnt_d = '0;
                    end else begin
                        pos_y_d = pos_new_s;
                        speed_d = speed_new_s;
                    end
                end
                ITEM_LANDED: begin
                    if (frame_cnt_q == CNT_W'(LINGER_FRAMES - 1)) begin
                        state_d     = ITEM_BLINK;
                        frame_cnt_d = '0;
                        phase_cnt_d = '0;
                        visible_d   = 1'b1;
                    end else begin
                        frame_cnt_d = frame_cnt_q + CNT_W'(1);
                    end
                end
                ITEM_BLINK: begin
                    if (frame_cnt_q == CNT_W'(BLINK_FRAMES - 1)) begin
                        state_d     = ITEM_IDLE;
                        frame_cnt_d = '0;
                        phase_cnt_d = '0;
                        visible_d   = 1'b1;
                    end else if (phase_cnt_q == PH_W'(BLINK_PERIOD - 1)) begin
                        frame_cnt_d = frame_cnt_q + CNT_W'(1);
                        phase_cnt_d = '0;
                        visible_d   = ~visible_q;
                    end else begin
                        frame_cnt_d = frame_cnt_q + CNT_W'(1);
                        phase_cnt_d = phase_cnt_q + PH_W'(1);
                    end
                end
                default: begin
                    state_d = ITEM_IDLE;
                end
            endcase
        end else if (spawn && !is_active_s) begin
            state_d     = ITEM_FALLING;
            tlx_d       = clamp_left_x(spawnX, COORD_W'(SCREEN_W - OBJ_W));
            pos_y_d     = '0;
            speed_d     = '0;
            frame_cnt_d = '0;
            phase_cnt_d = '0;
            visible_d   = 1'b1;
        end else begin
            state_d = state_q;
        end
    end

    // State registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ITEM_IDLE;
            tlx_q       <= '0;
            pos_y_q     <= '0;
            speed_q     <= '0;
            frame_cnt_q <= '0;
            phase_cnt_q <= '0;
            visible_q   <= 1'b1;
            pickup_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            tlx_q       <= tlx_d;
            pos_y_q     <= pos_y_d;
            speed_q     <= speed_d;
            frame_cnt_q <= frame_cnt_d;
            phase_cnt_q <= phase_cnt_d;
            visible_q   <= visible_d;
            pickup_q    <= pickup_d;
        end
    end

    rect_offset_calc #(
        .OBJ_W (OBJ_W),
        .OBJ_H (OBJ_H)
    ) u_rect (
        .clk_i        (clk),
        .reset_i      (reset),
        .pixel_x_i    (pixelX),
        .pixel_y_i    (pixelY),
        .top_left_x_i (tlx_q),
        .top_left_y_i (pos_y_q[POS_W-1:FRAC_BITS]),
        .enable_i     (is_active_s && visible_q),
        .offset_x_o   (offsetX),
        .offset_y_o   (offsetY),
        .inside_o     (InsideRectangle)
    );

    assign active = is_active_s;
    assign pickup = pickup_q;

endmodule

// File: tb/tb_bonus_item_mover.sv
// Randomized bench for bonus_item_mover against a frame-level behavioural model
// (integer pixel/sixteenth arithmetic, visibility derived from elapsed blink frames).
module tb_bonus_item_mover;

    logic        clk = 1'b0;
    logic        reset, startOfFrame, spawn, collected;
    logic [10:0] pixelX, pixelY, spawnX;
    logic [10:0] offsetX, offsetY;
    logic        InsideRectangle, active, pickup;

    int    n_tests = 0;
    int    n_fail  = 0;
    string phase   = "init";

    // model: 0 idle, 1 falling, 2 landed, 3 blink; vertical position in 1/16 px
    int m_state, m_tlx, m_pos16, m_speed, m_frames;

    always #5 clk = ~clk;

    bonus_item_mover dut (
        .clk             (clk),
        .reset           (reset),
        .startOfFrame    (startOfFrame),
        .pixelX          (pixelX),
        .pixelY          (pixelY),
        .spawn           (spawn),
        .spawnX          (spawnX),
        .collected       (collected),
        .offsetX         (offsetX),
        .offsetY         (offsetY),
        .InsideRectangle (InsideRectangle),
        .active          (active),
        .pickup          (pickup)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL [%s] %s: got %0d expected %0d", phase, tag, got, exp);
        end
    endtask

    function automatic bit m_visible();
        return (m_state != 3) || (((m_frames / 8) % 2) == 0);
    endfunction

    task automatic model_reset();
        m_state = 0; m_tlx = 0; m_pos16 = 0; m_speed = 0; m_frames = 0;
    endtask

    task automatic model_frame();
        case (m_state)
            1: begin
                m_speed = (m_speed + 2 > 64) ? 64 : m_speed + 2;
                m_pos16 = m_pos16 + m_speed;
                if ((m_pos16 / 16) + 25 >= 440) begin
                    m_pos16 = 415 * 16; m_speed = 0; m_state = 2; m_frames = 0;
                end
            end
            2: begin
                m_frames++;
                if (m_frames == 300) begin m_state = 3; m_frames = 0; end
            end
            3: begin
                m_frames++;
                if (m_frames == 120) begin m_state = 0; m_frames = 0; end
            end
            default: ;
        endcase
    endtask

    // One clock: drive inputs, predict from pre-edge model, advance model, compare all outputs.
    task automatic step(input bit sof, input bit spw, input int spx, input bit col,
                        input int px_in, input int py_in);
        int px, py, ty, e_in, e_ox, e_oy, e_pk;
        px = px_in & 2047;
        py = py_in & 2047;
        startOfFrame = sof; spawn = spw; spawnX = 11'(spx & 2047); collected = col;
        pixelX = 11'(px); pixelY = 11'(py);
        ty   = m_pos16 / 16;
        e_in = (m_state != 0 && m_visible() && px >= m_tlx && px < m_tlx + 25
                && py >= ty && py < ty + 25) ? 1 : 0;
        e_ox = e_in ? px - m_tlx : 0;
        e_oy = e_in ? py - ty : 0;
        e_pk = (col && m_state != 0) ? 1 : 0;
        @(posedge clk);
        #1;
        if (col && m_state != 0) m_state = 0;
        else if (sof && m_state != 0) model_frame();
        else if (spw && m_state == 0) begin
            m_state = 1; m_tlx = ((spx & 2047) > 615) ? 615 : (spx & 2047);
            m_pos16 = 0; m_speed = 0; m_frames = 0;
        end
        check_eq("InsideRectangle", InsideRectangle, e_in);
        check_eq("offsetX", offsetX, e_ox);
        check_eq("offsetY", offsetY, e_oy);
        check_eq("active", active, (m_state != 0) ? 1 : 0);
        check_eq("pickup", pickup, e_pk);
        startOfFrame = 1'b0; spawn = 1'b0; collected = 1'b0;
    endtask

    task automatic rand_px(output int px, output int py);
        px = m_tlx + $urandom_range(0, 40) - 8;
        py = m_pos16 / 16 + $urandom_range(0, 40) - 8;
    endtask

    task automatic frame_probe();
        int px, py;
        rand_px(px, py);
        step(1'b1, 1'b0, 0, 1'b0, px, py);
        rand_px(px, py);
        step(1'b0, 1'b0, 0, 1'b0, px, py);
    endtask

    task automatic do_reset(input bit col);
        reset = 1'b1; collected = col; startOfFrame = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0; collected = 1'b0; startOfFrame = 1'b0;
        model_reset();
        check_eq("rst_offsetX", offsetX, 0);
        check_eq("rst_offsetY", offsetY, 0);
        check_eq("rst_inside", InsideRectangle, 0);
        check_eq("rst_active", active, 0);
        check_eq("rst_pickup", pickup, 0);
    endtask

    task automatic run_to_blink(input int extra);
        for (int i = 0; i < 600 && m_state != 3; i++) step(1'b1, 1'b0, 0, 1'b0, m_tlx + 12, 427);
        for (int i = 0; i < extra; i++) step(1'b1, 1'b0, 0, 1'b0, m_tlx + 12, 427);
    endtask

    initial begin
        int r, px, py;
        reset = 1'b1; startOfFrame = 1'b0; spawn = 1'b0; collected = 1'b0;
        spawnX = '0; pixelX = '0; pixelY = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        phase = "reset";
        do_reset(1'b0);

        phase = "idle_collect";
        step(1'b0, 1'b0, 0, 1'b1, 10, 10);

        phase = "fall";
        step(1'b0, 1'b1, 300, 1'b0, 0, 0);
        step(1'b0, 1'b0, 0, 1'b0, 300, 0);
        check_eq("spawn_corner_in", InsideRectangle, 1);
        for (int f = 0; f < 200 && m_state == 1; f++) frame_probe();

        phase = "landed";
        step(1'b0, 1'b0, 0, 1'b0, 324, 439);
        check_eq("land_far_corner_in", InsideRectangle, 1);
        check_eq("land_far_corner_ox", offsetX, 24);
        check_eq("land_far_corner_oy", offsetY, 24);
        step(1'b0, 1'b0, 0, 1'b0, 325, 439);
        check_eq("land_x25_out", InsideRectangle, 0);
        step(1'b0, 1'b0, 0, 1'b0, 324, 440);
        check_eq("land_y25_out", InsideRectangle, 0);
        step(1'b0, 1'b0, 0, 1'b0, 300, 414);
        check_eq("land_above_out", InsideRectangle, 0);

        phase = "spawn_while_active";
        step(1'b0, 1'b1, 0, 1'b0, 300, 415);
        step(1'b0, 1'b0, 0, 1'b0, 300, 415);
        check_eq("no_restart_in", InsideRectangle, 1);

        phase = "linger_blink";
        for (int f = 0; f < 300; f++) step(1'b1, 1'b0, 0, 1'b0, 312, 427);
        for (int f = 0; f < 120; f++) begin
            step(1'b1, 1'b0, 0, 1'b0, 312, 427);
            step(1'b0, 1'b0, 0, 1'b0, 312, 427);
            if (f >= 7 && f <= 14) check_eq("blink_hidden", InsideRectangle, 0);
        end
        check_eq("expired_inactive", active, 0);

        phase = "clamp";
        step(1'b0, 1'b1, 630, 1'b0, 0, 0);
        step(1'b0, 1'b0, 0, 1'b0, 615, 5);
        check_eq("clamp_ox0_in", InsideRectangle, 1);
        check_eq("clamp_ox0", offsetX, 0);
        step(1'b0, 1'b0, 0, 1'b0, 640, 5);
        check_eq("clamp_x640_out", InsideRectangle, 0);
        repeat (5) frame_probe();

        phase = "collect_fall";
        step(1'b0, 1'b1, 100, 1'b1, 620, 20);
        check_eq("collect_pickup", pickup, 1);
        check_eq("collect_inactive", active, 0);
        step(1'b0, 1'b0, 0, 1'b0, 620, 20);
        check_eq("pickup_one_cycle", pickup, 0);

        phase = "collect_with_sof";
        step(1'b0, 1'b1, 50, 1'b0, 60, 5);
        step(1'b1, 1'b0, 0, 1'b1, 60, 5);
        step(1'b0, 1'b0, 0, 1'b0, 60, 5);

        phase = "collect_invisible";
        step(1'b0, 1'b1, 200, 1'b0, 0, 0);
        run_to_blink(10);
        step(1'b0, 1'b0, 0, 1'b0, 212, 427);
        step(1'b0, 1'b0, 0, 1'b1, 212, 427);
        check_eq("invisible_pickup", pickup, 1);

        phase = "reset_mid_blink";
        step(1'b0, 1'b1, 400, 1'b0, 0, 0);
        run_to_blink(3);
        do_reset(1'b1);

        phase = "random";
        for (int i = 0; i < 3000; i++) begin
            r = $urandom_range(0, 99);
            rand_px(px, py);
            if (r < 30)      step(1'b1, 1'b0, 0, 1'b0, px, py);
            else if (r < 34) step(1'b0, 1'b1, $urandom_range(0, 2047), 1'b0, px, py);
            else if (r < 35) step(1'b0, 1'b0, 0, 1'b1, px, py);
            else if (r < 36) do_reset($urandom_range(0, 1));
            else             step(1'b0, 1'b0, 0, 1'b0, px, py);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
